i2c_slave_regfile: RTL and testbench
====================================

// Module: i2c_slave_regfile
// PURPOSE
//  System-clocked I2C target (7-bit addressing) fronting a DEPTH x 8 register file.
//  Successor of the SCL-clocked address/ACK-only slave: supports write, read,
//  repeated START, and pointer auto-increment.
//  Sits between the board I2C pads (open-drain, external pull-up) and on-chip logic,
//  which reads registers through a side port.
// PARAMETERS
//  I2C_ADR   7'h13  7-bit target address
//  DEPTH     16     register count; power of two, 2..256; pointer width PW = clog2(DEPTH)
//  FILT_LEN  3      glitch-filter length in clk cycles; used only with I2C_SLV_GLITCH_FILT_EN
// PORTS
//  clk         in   1   system clock; must be >= 16x SCL rate
//  rst         in   1   asynchronous reset, active-high
//  scl_i       in   1   SCL pad input (asynchronous)
//  sda_i       in   1   SDA pad input (asynchronous)
//  sda_oe      out  1   1 = pull SDA low; 0 = release. Pad: SDA = sda_oe ? 0 : z
//  host_addr   in   PW  register index for host read port
//  host_rdata  out  8   regfile[host_addr]; combinational
//  wr_strobe   out  1   1-clk pulse when an I2C data byte is written
//  wr_index    out  PW  index written on the wr_strobe cycle
//  busy        out  1   1 from address match to STOP or non-matching START
// BEHAVIOUR
//  - Input path: scl_i and sda_i each pass through a 2-flop synchroniser.
//  - scl_rise/scl_fall: 1-clk pulses from the synchronised SCL.
//  - START: synced SDA 1->0 while SCL high. STOP: synced SDA 0->1 while SCL high.
//  - Bits are sampled on scl_rise. sda_oe changes only on scl_fall, so it is stable while SCL is high.
//  - FSM states:
//    IDLE, ADDR(8b), ADDR_ACK, PTR(8b), PTR_ACK, WDATA(8b), WDATA_ACK, RDATA(8b), RD_MACK.
//  - START from any state -> ADDR, bit count 7.
//    Repeated START keeps the pointer and is valid even without an intervening STOP.
//  - STOP from any state -> IDLE: sda_oe=0, busy=0.
//  - ADDR complete, addr == I2C_ADR:
//    - drive ACK through the 9th clock, busy=1.
//    - R/W=0 -> PTR; R/W=1 -> RDATA, load shift register from regfile[ptr].
//  - ADDR mismatch -> IDLE, no ACK (SDA stays released); waits for the next START.
//  - PTR byte: ptr <= byte[PW-1:0]; upper bits ignored; ACK always; then WDATA.
//  - WDATA byte:
//    - regfile[ptr] <= byte; wr_strobe pulses on that clk; wr_index = ptr.
//    - ACK always; ptr <= ptr+1, wrapping DEPTH-1 -> 0.
//  - RDATA: MSB first.
//    - Each bit is driven on the scl_fall; sda_oe = ~bit.
//    - The first bit is driven on the scl_fall ending the address ACK.
//  - RD_MACK: release SDA, sample the master's bit on scl_rise, and ptr <= ptr+1 (wrap).
//    - ACK (0): reload from regfile[ptr] -> RDATA.
//    - NACK (1): go to IDLE-wait; SDA stays released until STOP/START.
//  - Host read port is combinational and unaffected by I2C state.
//  - Reset (async, any time, including mid-byte):
//    - state IDLE, ptr=0, all regs 0.
//    - sda_oe=0, busy=0, wr_strobe=0, wr_index=0.
//  - First START after reset release is honoured only if SCL/SDA have been seen high
//    for >= 2 synced clks (bus-idle guard).
//  - Latency: at most 3 clk from pad edge to internal action (4+FILT_LEN with filter).
// CONFIGURATION
//  I2C_SLV_GLITCH_FILT_EN defined:
//    - Each synced line passes a majority/hold filter.
//    - A new level is accepted only after FILT_LEN consecutive equal samples.
//    - Pulses shorter than FILT_LEN clk are ignored (I2C 50 ns spike rule).
//  Undefined: no filter; synchroniser outputs are used directly.
// TESTING
//  - Write then read back:
//    - S 0x26 A, 0x03 A, 0xA5 A, 0x5A A, P -> reg3=A5, reg4=5A; wr_strobe x2, wr_index 3 then 4.
//    - host_addr=4 -> host_rdata=5A.
//  - Random read with repeated START:
//    - S 0x26, 0x03, Sr 0x27, master ACK then NACK -> SDA bytes A5, 5A; SDA released after the NACK.
//  - Wrong address: S 0x28 ... -> sda_oe never asserted, busy=0, regs unchanged.
//  - Pointer wrap: S 0x26, 0x0F, 0x11, 0x22, P -> reg15=11, reg0=22.
//  - Reset mid-transfer: rst pulse during the 4th data bit -> sda_oe=0, busy=0, regs=0;
//    the next full transaction completes normally.
//  - Filter build only: 1-clk low glitch on SCL while high -> no bit counted, no START/STOP detected.

Source files
------------

// File: rtl/i2c_slave_regfile.sv
// i2c_slave_regfile
// System-clocked I2C target (7-bit address) in front of a DEPTH x 8 register
// file. Supports pointer write, data write with auto-increment, read with
// auto-increment, and repeated START. On-chip logic reads the registers
// combinationally through the host port.
// Optional glitch filter on the synchronised lines: define I2C_SLV_GLITCH_FILT_EN.
module i2c_slave_regfile #(
  parameter logic [6:0] I2C_ADR  = 7'h13,
  parameter int         DEPTH    = 16,
  parameter int         FILT_LEN = 3,
  localparam int        PW       = $clog2(DEPTH)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          scl_i,
  input  logic          sda_i,
  output logic          sda_oe,
  input  logic [PW-1:0] host_addr,
  output logic [7:0]    host_rdata,
  output logic          wr_strobe,
  output logic [PW-1:0] wr_index,
  output logic          busy
);

  typedef enum logic [3:0] {
    IDLE, ADDR, ADDR_ACK, PTR, PTR_ACK, WDATA, WDATA_ACK, RDATA, RD_MACK
  } state_t;

  // Reject configurations the pointer arithmetic cannot handle.
  if (DEPTH < 2 || DEPTH > 256 || (DEPTH & (DEPTH - 1)) != 0 || FILT_LEN < 1) begin : g_bad_cfg
    $error("i2c_slave_regfile: DEPTH must be a power of two in 2..256 and FILT_LEN >= 1");
  end

  state_t        state_q, state_d;
  logic          scl_s1, scl_s2, sda_s1, sda_s2;
  logic          scl_f, sda_f;
  logic          scl_d, sda_d;
  logic          scl_rise, scl_fall, start_raw, start_ok, stop_det;
  logic          idle_seen, armed;
  logic [2:0]    cnt;
  logic [7:0]    shift;
  logic          last_bit;
  logic          rw;
  logic [PW-1:0] ptr;
  logic [7:0]    regs [DEPTH];
  logic [7:0]    rx_byte;
  logic          rx_last;
  logic          addr_hit;

  // Two-flop synchronisers for the asynchronous pad inputs.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      scl_s1 <= 1'b0;
      scl_s2 <= 1'b0;
      sda_s1 <= 1'b0;
      sda_s2 <= 1'b0;
    end else begin
      scl_s1 <= scl_i;
      scl_s2 <= scl_s1;
      sda_s1 <= sda_i;
      sda_s2 <= sda_s1;
    end
  end

`ifdef I2C_SLV_GLITCH_FILT_EN
  localparam int FW = (FILT_LEN > 1) ? $clog2(FILT_LEN) : 1;
  logic [FW-1:0] scl_fcnt, sda_fcnt;

  // SCL hold filter: adopt a new level only after FILT_LEN consecutive samples.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      scl_f    <= 1'b0;
      scl_fcnt <= '0;
    end else if (scl_s2 != scl_f) begin
      if (scl_fcnt == FW'(FILT_LEN - 1)) begin
        scl_f    <= scl_s2;
        scl_fcnt <= '0;
      end else begin
        scl_fcnt <= scl_fcnt + FW'(1);
      end
    end else begin
      scl_fcnt <= '0;
    end
  end

  // SDA hold filter, same rule as SCL.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sda_f    <= 1'b0;
      sda_fcnt <= '0;
    end else if (sda_s2 != sda_f) begin
      if (sda_fcnt == FW'(FILT_LEN - 1)) begin
        sda_f    <= sda_s2;
        sda_fcnt <= '0;
      end else begin
        sda_fcnt <= sda_fcnt + FW'(1);
      end
    end else begin
      sda_fcnt <= '0;
    end
  end
`else
  assign scl_f = scl_s2;
  assign sda_f = sda_s2;
`endif

  // Previous line levels for edge and bus-condition detection, plus the
  // bus-idle guard that arms START detection after two idle-high samples.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      scl_d     <= 1'b0;
      sda_d     <= 1'b0;
      idle_seen <= 1'b0;
      armed     <= 1'b0;
    end else begin
      scl_d <= scl_f;
      sda_d <= sda_f;
      if (!armed) begin
        idle_seen <= scl_f & sda_f;
        armed     <= idle_seen & scl_f & sda_f;
      end
    end
  end

  assign scl_rise  = scl_f & ~scl_d;
  assign scl_fall  = ~scl_f & scl_d;
  assign start_raw = scl_f & scl_d & sda_d & ~sda_f;
  assign stop_det  = scl_f & scl_d & ~sda_d & sda_f;
  assign start_ok  = start_raw & armed;

  assign rx_byte  = {shift[6:0], sda_f};
  assign rx_last  = scl_rise && (cnt == 3'd0);
  assign addr_hit = (rx_byte[7:1] == I2C_ADR);

  // FSM state register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_q <= IDLE;
    else     state_q <= state_d;
  end

  // FSM next-state logic; STOP and START override every state.
  always_comb begin
    state_d = state_q;
    if (stop_det) begin
      state_d = IDLE;
    end else if (start_ok) begin
      state_d = ADDR;
    end else begin
      unique case (state_q)
        IDLE:      state_d = IDLE;
        ADDR: begin
          if (rx_last && !addr_hit)      state_d = IDLE;
          else if (scl_fall && last_bit) state_d = ADDR_ACK;
        end
        PTR:       if (scl_fall && last_bit) state_d = PTR_ACK;
        WDATA:     if (scl_fall && last_bit) state_d = WDATA_ACK;
        ADDR_ACK:  if (scl_fall) state_d = rw ? RDATA : PTR;
        PTR_ACK:   if (scl_fall) state_d = WDATA;
        WDATA_ACK: if (scl_fall) state_d = WDATA;
        RDATA:     if (scl_fall && last_bit) state_d = RD_MACK;
        RD_MACK: begin
          if (scl_rise && sda_f)         state_d = IDLE;
          else if (scl_fall && last_bit) state_d = RDATA;
        end
        default:   state_d = IDLE;
      endcase
    end
  end

  // FSM outputs: ACK slots pull SDA low, read bits drive the shift MSB.
  always_comb begin
    sda_oe = 1'b0;
    unique case (state_q)
      ADDR_ACK, PTR_ACK, WDATA_ACK: sda_oe = 1'b1;
      RDATA:                        sda_oe = ~shift[7];
      default:                      sda_oe = 1'b0;
    endcase
  end

  // Datapath: bit counter, shift register, pointer, register file and strobes.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt       <= 3'd7;
      shift     <= 8'h00;
      last_bit  <= 1'b0;
      rw        <= 1'b0;
      ptr       <= '0;
      busy      <= 1'b0;
      wr_strobe <= 1'b0;
      wr_index  <= '0;
      for (int i = 0; i < DEPTH; i++) regs[i] <= 8'h00;
    end else begin
      wr_strobe <= 1'b0;
      if (stop_det) begin
        last_bit <= 1'b0;
        busy     <= 1'b0;
      end else if (start_ok) begin
        cnt      <= 3'd7;
        last_bit <= 1'b0;
      end else begin
        unique case (state_q)
          ADDR, PTR, WDATA: begin
            if (scl_rise) begin
              shift <= rx_byte;
              cnt   <= cnt - 3'd1;
              if (cnt == 3'd0) begin
                last_bit <= 1'b1;
                if (state_q == ADDR) begin
                  rw   <= rx_byte[0];
                  busy <= addr_hit;
                end else if (state_q == PTR) begin
                  ptr <= rx_byte[PW-1:0];
                end else begin
                  regs[ptr] <= rx_byte;
                  wr_strobe <= 1'b1;
                  wr_index  <= ptr;
                  ptr       <= ptr + PW'(1);
                end
              end
            end else if (scl_fall && last_bit) begin
              last_bit <= 1'b0;
            end
          end
          ADDR_ACK: begin
            if (scl_fall) begin
              cnt <= 3'd7;
              if (rw) shift <= regs[ptr];
            end
          end
          PTR_ACK, WDATA_ACK: begin
            if (scl_fall) cnt <= 3'd7;
          end
          RDATA: begin
            if (scl_rise) begin
              cnt <= cnt - 3'd1;
              if (cnt == 3'd0) last_bit <= 1'b1;
            end else if (scl_fall) begin
              if (last_bit) last_bit <= 1'b0;
              else          shift    <= {shift[6:0], 1'b0};
            end
          end
          RD_MACK: begin
            if (scl_rise) begin
              ptr <= ptr + PW'(1);
              if (!sda_f) last_bit <= 1'b1;
            end else if (scl_fall && last_bit) begin
              last_bit <= 1'b0;
              shift    <= regs[ptr];
              cnt      <= 3'd7;
            end
          end
          default: ;
        endcase
      end
    end
  end

  assign host_rdata = regs[host_addr];

endmodule

// File: tb/tb_i2c_slave_regfile.sv
// tb_i2c_slave_regfile
// Bit-banged I2C master driving the register-file target, with a
// transaction-level model of the register file and pointer.
module tb_i2c_slave_regfile;

  localparam int Q = 6;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       scl = 1'b1;
  logic       sda_m = 1'b1;
  logic       sda_bus;
  logic       sda_oe;
  logic [3:0] host_addr = 4'd0;
  logic [7:0] host_rdata;
  logic       wr_strobe;
  logic [3:0] wr_index;
  logic       busy;

  int checks = 0;
  int errors = 0;

  logic [7:0]  mdl_mem [16];
  logic [3:0]  mdl_ptr;
  logic [11:0] exp_q [$];
  logic [3:0]  strobe_log [$];
  logic [7:0]  wbuf [4];
  logic [7:0]  rbuf [4];
  logic        host_rand = 1'b0;
  logic        oe_seen = 1'b0;
  logic        scl_prev = 1'b1;
  logic        oe_prev = 1'b0;
  logic        rst_prev = 1'b1;

  assign sda_bus = sda_m & ~sda_oe;

  i2c_slave_regfile #(.I2C_ADR(7'h13), .DEPTH(16), .FILT_LEN(3)) dut (
    .clk(clk),
    .rst(rst),
    .scl_i(scl),
    .sda_i(sda_bus),
    .sda_oe(sda_oe),
    .host_addr(host_addr),
    .host_rdata(host_rdata),
    .wr_strobe(wr_strobe),
    .wr_index(wr_index),
    .busy(busy)
  );

  always #5 clk = ~clk;

  initial begin
    #1500000;
    $display("[TB] FAIL watchdog: got timeout expected finish");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic modelReset();
    for (int i = 0; i < 16; i++) mdl_mem[i] = 8'h00;
    mdl_ptr = 4'd0;
    exp_q.delete();
  endtask

  // Compare process: write strobes against the expected-write queue and the
  // host port against the model whenever no write is in flight.
  always @(negedge clk) begin
    logic [11:0] e;
    if (!rst) begin
      if (wr_strobe) begin
        checkOutput("write_expected", 32'(exp_q.size() > 0), 1);
        if (exp_q.size() > 0) begin
          e = exp_q.pop_front();
          checkOutput("wr_index", wr_index, e[11:8]);
          strobe_log.push_back(wr_index);
        end
      end
      if (exp_q.size() == 0) checkOutput("host_rdata", host_rdata, mdl_mem[host_addr]);
      if (scl && scl_prev && !rst_prev) checkOutput("oe_stable_scl_high", sda_oe, oe_prev);
      if (sda_oe) oe_seen = 1'b1;
    end
    scl_prev = scl;
    oe_prev  = sda_oe;
    rst_prev = rst;
  end

  task automatic waitClks(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
      if (host_rand) host_addr = 4'($urandom);
    end
  endtask

  task automatic sendBit(input logic b, output logic seen);
    sda_m = b;
    waitClks(Q);
    scl = 1'b1;
    waitClks(Q);
    seen = sda_bus;
    waitClks(Q);
    scl = 1'b0;
    waitClks(Q);
  endtask

  task automatic startCond();
    sda_m = 1'b1;
    waitClks(Q);
    scl = 1'b1;
    waitClks(Q);
    sda_m = 1'b0;
    waitClks(Q);
    scl = 1'b0;
    waitClks(Q);
  endtask

  task automatic stopCond();
    sda_m = 1'b0;
    waitClks(Q);
    scl = 1'b1;
    waitClks(Q);
    sda_m = 1'b1;
    waitClks(2 * Q);
  endtask

  task automatic sendByte(input logic [7:0] b, output logic ack);
    logic s;
    for (int i = 7; i >= 0; i--) sendBit(b[i], s);
    sendBit(1'b1, ack);
  endtask

  task automatic recvByte(input logic mack, output logic [7:0] b);
    logic s;
    b = 8'h00;
    for (int i = 0; i < 8; i++) begin
      sendBit(1'b1, s);
      b = {b[6:0], s};
    end
    sendBit(mack, s);
  endtask

  // Write transaction: pointer byte then n data bytes from wbuf.
  task automatic doWrite(input logic [7:0] p, input int n);
    logic ack;
    startCond();
    sendByte(8'h26, ack);
    checkOutput("addr_ack_w", ack, 0);
    checkOutput("busy_match_w", busy, 1);
    sendByte(p, ack);
    checkOutput("ptr_ack", ack, 0);
    mdl_ptr = p[3:0];
    for (int i = 0; i < n; i++) begin
      exp_q.push_back({mdl_ptr, wbuf[i]});
      mdl_mem[mdl_ptr] = wbuf[i];
      sendByte(wbuf[i], ack);
      checkOutput("data_ack", ack, 0);
      mdl_ptr = mdl_ptr + 4'd1;
    end
    stopCond();
    checkOutput("busy_after_stop_w", busy, 0);
  endtask

  // Read transaction, optionally setting the pointer first via repeated START.
  task automatic doRead(input logic set_ptr, input logic [7:0] p, input int n);
    logic ack;
    logic [7:0] b;
    startCond();
    if (set_ptr) begin
      sendByte(8'h26, ack);
      checkOutput("addr_ack_rp", ack, 0);
      sendByte(p, ack);
      checkOutput("ptr_ack_r", ack, 0);
      mdl_ptr = p[3:0];
      startCond();
    end
    sendByte(8'h27, ack);
    checkOutput("addr_ack_r", ack, 0);
    checkOutput("busy_match_r", busy, 1);
    for (int i = 0; i < n; i++) begin
      recvByte(i == n - 1, b);
      checkOutput("rdata", b, mdl_mem[mdl_ptr]);
      rbuf[i] = b;
      mdl_ptr = mdl_ptr + 4'd1;
    end
    checkOutput("sda_released_nack", sda_oe, 0);
    checkOutput("busy_until_stop", busy, 1);
    stopCond();
    checkOutput("busy_after_stop_r", busy, 0);
  endtask

  // Transaction to a foreign address: no ACK, no drive, no busy.
  task automatic doBadAddr(input logic [7:0] a);
    logic ack;
    oe_seen = 1'b0;
    startCond();
    sendByte(a, ack);
    checkOutput("bad_addr_nack", ack, 1);
    sendByte(8'($urandom), ack);
    checkOutput("bad_data_nack", ack, 1);
    checkOutput("bad_busy", busy, 0);
    stopCond();
    checkOutput("bad_oe_seen", oe_seen, 0);
  endtask

  // Random mix of writes, pointer reads, current-address reads, foreign addresses.
  task automatic applyStimulus(input int count);
    int kind;
    int n;
    logic [7:0] a;
    for (int t = 0; t < count; t++) begin
      kind = $urandom_range(0, 3);
      n = $urandom_range(1, 3);
      case (kind)
        0: begin
          for (int i = 0; i < n; i++) wbuf[i] = 8'($urandom);
          doWrite(8'($urandom), n);
        end
        1: doRead(1'b1, 8'($urandom), n);
        2: doRead(1'b0, 8'h00, n);
        default: begin
          a = 8'($urandom);
          if (a[7:1] == 7'h13) a[7:1] = 7'h14;
          doBadAddr(a);
        end
      endcase
    end
  endtask

  initial begin
    logic s;
    modelReset();
    waitClks(3);
    checkOutput("reset_sda_oe", sda_oe, 0);
    checkOutput("reset_busy", busy, 0);
    checkOutput("reset_wr_strobe", wr_strobe, 0);
    checkOutput("reset_wr_index", wr_index, 0);
    checkOutput("reset_host_rdata", host_rdata, 0);
    rst = 1'b0;
    waitClks(10);

    $display("[TB] write then read back");
    strobe_log.delete();
    wbuf[0] = 8'hA5;
    wbuf[1] = 8'h5A;
    doWrite(8'h03, 2);
    waitClks(2);
    checkOutput("strobe_count", strobe_log.size(), 2);
    if (strobe_log.size() == 2) begin
      checkOutput("strobe_idx0", strobe_log[0], 3);
      checkOutput("strobe_idx1", strobe_log[1], 4);
    end
    host_addr = 4'd4;
    #1;
    checkOutput("host_reg4", host_rdata, 8'h5A);
    host_addr = 4'd3;
    #1;
    checkOutput("host_reg3", host_rdata, 8'hA5);

    $display("[TB] random read with repeated START");
    doRead(1'b1, 8'h03, 2);
    checkOutput("rd_byte0", rbuf[0], 8'hA5);
    checkOutput("rd_byte1", rbuf[1], 8'h5A);

    $display("[TB] wrong address");
    doBadAddr(8'h28);
    host_addr = 4'd3;
    #1;
    checkOutput("bad_reg3_kept", host_rdata, 8'hA5);

    $display("[TB] pointer wrap");
    strobe_log.delete();
    wbuf[0] = 8'h11;
    wbuf[1] = 8'h22;
    doWrite(8'h0F, 2);
    waitClks(2);
    host_addr = 4'd15;
    #1;
    checkOutput("wrap_reg15", host_rdata, 8'h11);
    host_addr = 4'd0;
    #1;
    checkOutput("wrap_reg0", host_rdata, 8'h22);
    if (strobe_log.size() == 2) checkOutput("wrap_idx1", strobe_log[1], 0);
    else checkOutput("wrap_strobe_count", strobe_log.size(), 2);

    $display("[TB] reset mid-transfer");
    startCond();
    sendByte(8'h26, s);
    sendByte(8'h00, s);
    for (int i = 0; i < 3; i++) sendBit(1'b1, s);
    sda_m = 1'b1;
    waitClks(Q);
    scl = 1'b1;
    waitClks(2);
    #2;
    rst = 1'b1;
    modelReset();
    waitClks(2);
    checkOutput("mid_rst_sda_oe", sda_oe, 0);
    checkOutput("mid_rst_busy", busy, 0);
    checkOutput("mid_rst_wr_index", wr_index, 0);
    rst = 1'b0;
    waitClks(Q);
    scl = 1'b0;
    waitClks(Q);
    scl = 1'b1;
    waitClks(4 * Q);
    for (int i = 0; i < 16; i++) begin
      host_addr = 4'(i);
      #1;
      checkOutput("mid_rst_reg_zero", host_rdata, 0);
    end
    wbuf[0] = 8'hC3;
    wbuf[1] = 8'h3C;
    doWrite(8'h07, 2);
    doRead(1'b1, 8'h07, 2);

    $display("[TB] randomized transactions");
    host_rand = 1'b1;
    applyStimulus(20);
    waitClks(4);
    checkOutput("pending_writes", exp_q.size(), 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
